// File: rtl/cronometro_pkg.sv
// cronometro_pkg -- shared definitions for the cronometro stopwatch control.
//   state_t    : 2-bit FSM encoding (PARADO, CONTANDO, PAUSADO, ESTOURO)
//   CNT_W      : width of the tenth-of-second count (10 bits, 0..1023)
//   calc_div() : prescaler divide ratio, clock cycles per count tick
package cronometro_pkg;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ST_PARADO   = 2'd0,
        ST_CONTANDO = 2'd1,
        ST_PAUSADO  = 2'd2,
        ST_ESTOURO  = 2'd3
    } state_t;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/cronometro_ctrl_divisor_tick.sv
// divisor_tick -- tick prescaler for the stopwatch.
//   clk  in  system clock
//   rst  in  synchronous reset, active-high (counter -> 0)
//   en   in  count enable; the counter holds its phase while low
//   clr  in  synchronous clear to 0, wins over en
//   tick out 1-cycle pulse on the enabled cycle where the counter is at DIV-1
// The counter runs 0..DIV-1 and wraps to 0 on the tick cycle.
module divisor_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cronometro_ctrl.sv
// cronometro_ctrl -- stopwatch control FSM for the cronometro datapath.
// Turns start/stop, clear and lap button levels into a saturating 0..MAX_COUNT
// tenth-of-second count and presents it (registered) to the BCD/7-seg path.
//   clk            in   system clock
//   rst            in   synchronous reset, active-high
//   btn_start_stop in   start/pause level (debounced, synchronous)
//   btn_zerar      in   clear level (debounced)
//   btn_volta      in   lap level (debounced), used only with CRONOMETRO_LAP_EN
//   bin            out  [9:0] count, or frozen lap value while a lap is shown
//   contando       out  high in state CONTANDO
//   estouro        out  high in state ESTOURO
//   volta_ativa    out  high while bin shows the frozen lap value
// Build option: define CRONOMETRO_LAP_EN to enable the lap freeze; without it
// btn_volta is ignored, volta_ativa is 0 and bin always shows the count.
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 10,
    parameter int MAX_COUNT = 999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start_stop,
    input  logic             btn_zerar,
    input  logic             btn_volta,
    output logic [CNT_W-1:0] bin,
    output logic             contando,
    output logic             estouro,
    output logic             volta_ativa
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    // ---------------------------------------------------------------
    // Button edge detect. The level registers follow the inputs even
    // in reset, so a button held through reset is not seen as a new
    // press afterwards; only the event pulses are cleared by reset.
    // ---------------------------------------------------------------
    logic ss_lvl_q, z_lvl_q;
    logic ev_ss_q, ev_ss_d, ev_z_q, ev_z_d;

    always_comb begin
        ev_ss_d = btn_start_stop & ~ss_lvl_q;
        ev_z_d  = btn_zerar & ~z_lvl_q;
    end

    always_ff @(posedge clk) begin
        ss_lvl_q <= btn_start_stop;
        z_lvl_q  <= btn_zerar;
        if (rst) begin
            ev_ss_q <= 1'b0;
            ev_z_q  <= 1'b0;
        end else begin
            ev_ss_q <= ev_ss_d;
            ev_z_q  <= ev_z_d;
        end
    end

    // ---------------------------------------------------------------
    // Prescaler: runs only in CONTANDO, holds during pause so a resume
    // keeps the phase, cleared on start from PARADO and on zerar.
    // ---------------------------------------------------------------
    state_t state_q, state_d;
    logic   presc_en, presc_clr, tick;

    assign presc_en  = (state_q == ST_CONTANDO) && !ev_z_q;
    assign presc_clr = ev_z_q || ((state_q == ST_PARADO) && ev_ss_q);

    divisor_tick #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    // ---------------------------------------------------------------
    // Lap freeze
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lap_q;
    logic             volta_q;

`ifdef CRONOMETRO_LAP_EN
    logic             v_lvl_q, ev_v_q, ev_v_d;
    logic [CNT_W-1:0] lap_d;
    logic             volta_d;
    logic             lap_ok;

    // Lap only while the clock is live (or overflowed); a start_stop
    // event in CONTANDO outranks it. In ESTOURO start_stop is ignored,
    // so it cannot block the lap there.
    assign lap_ok = (state_q == ST_ESTOURO) ||
                    ((state_q == ST_CONTANDO) && !ev_ss_q);

    always_comb begin
        ev_v_d  = btn_volta & ~v_lvl_q;
        lap_d   = lap_q;
        volta_d = volta_q;
        if (ev_z_q) begin
            volta_d = 1'b0;
        end else if (ev_v_q && lap_ok) begin
            if (!volta_q) begin
                lap_d   = cnt_q;
                volta_d = 1'b1;
            end else begin
                volta_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        v_lvl_q <= btn_volta;
        if (rst) begin
            ev_v_q  <= 1'b0;
            lap_q   <= '0;
            volta_q <= 1'b0;
        end else begin
            ev_v_q  <= ev_v_d;
            lap_q   <= lap_d;
            volta_q <= volta_d;
        end
    end
`else
    logic volta_unused;
    assign volta_unused = btn_volta;
    assign lap_q        = '0;
    assign volta_q      = 1'b0;
`endif

    // ---------------------------------------------------------------
    // FSM: next-state / count
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ev_z_q) begin
            state_d = ST_PARADO;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_PARADO: begin
                    if (ev_ss_q) state_d = ST_CONTANDO;
                end
                ST_CONTANDO: begin
                    // The tick is applied first; a same-cycle start_stop
                    // then pauses, unless the tick just overflowed.
                    if (tick) begin
                        if (cnt_q == MAX_C) state_d = ST_ESTOURO;
                        else                cnt_d   = cnt_q + 1'b1;
                    end
                    if (ev_ss_q && (state_d == ST_CONTANDO)) state_d = ST_PAUSADO;
                end
                ST_PAUSADO: begin
                    if (ev_ss_q) state_d = ST_CONTANDO;
                end
                ST_ESTOURO: begin
                    state_d = ST_ESTOURO;
                end
                default: state_d = ST_PARADO;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FSM: outputs (registered below, one cycle behind the state)
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] bin_q, bin_d;
    logic             contando_q, contando_d;
    logic             estouro_q, estouro_d;
    logic             volta_ativa_q, volta_ativa_d;

    always_comb begin
        bin_d         = volta_q ? lap_q : cnt_q;
        contando_d    = (state_q == ST_CONTANDO);
        estouro_d     = (state_q == ST_ESTOURO);
        volta_ativa_d = volta_q;
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_PARADO;
            cnt_q         <= '0;
            bin_q         <= '0;
            contando_q    <= 1'b0;
            estouro_q     <= 1'b0;
            volta_ativa_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bin_q         <= bin_d;
            contando_q    <= contando_d;
            estouro_q     <= estouro_d;
            volta_ativa_q <= volta_ativa_d;
        end
    end

    assign bin         = bin_q;
    assign contando    = contando_q;
    assign estouro     = estouro_q;
    assign volta_ativa = volta_ativa_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Bench for cronometro_ctrl (CLK_HZ=10, TICK_HZ=1 -> 10 clocks per count,
// MAX_COUNT=12). A stopwatch reference model predicts every output cycle;
// predictions are queued by the driver and compared by an independent monitor.
module tb_cronometro_ctrl;

    localparam int DIV  = 10;
    localparam int MAXC = 12;

    // reference model modes
    localparam int IDLE = 0, RUN = 1, HOLD = 2, OVF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start_stop = 1'b0;
    logic       btn_zerar = 1'b0;
    logic       btn_volta = 1'b0;
    logic [9:0] bin;
    logic       contando, estouro, volta_ativa;

    cronometro_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .MAX_COUNT(MAXC)) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (btn_start_stop),
        .btn_zerar      (btn_zerar),
        .btn_volta      (btn_volta),
        .bin            (bin),
        .contando       (contando),
        .estouro        (estouro),
        .volta_ativa    (volta_ativa)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [9:0] bin;
        logic       c, e, v;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // model state: what a stopwatch "knows"
    int m_mode = IDLE, m_cnt = 0, m_phase = 0, m_lap = 0;
    bit m_lap_on = 0;
    bit p_ss = 0, p_z = 0, p_v = 0;   // button events taking effect next clock
    bit l_ss = 0, l_z = 0, l_v = 0;   // last sampled button levels

    // Advance the model by one clock with the given inputs and queue the
    // outputs expected right after that clock edge.
    task automatic model_step(input bit r, input bit ss, input bit z, input bit v);
        exp_t e;
        int   mode0, cnt0;
        e.cyc = cyc;
        if (r) begin
            e.bin = '0; e.c = 1'b0; e.e = 1'b0; e.v = 1'b0;
            m_mode = IDLE; m_cnt = 0; m_phase = 0; m_lap = 0; m_lap_on = 0;
            p_ss = 0; p_z = 0; p_v = 0;
        end else begin
            e.bin = 10'(m_lap_on ? m_lap : m_cnt);
            e.c   = (m_mode == RUN);
            e.e   = (m_mode == OVF);
            e.v   = m_lap_on;
            mode0 = m_mode;
            cnt0  = m_cnt;
            if (p_z) begin
                m_mode = IDLE; m_cnt = 0; m_phase = 0; m_lap_on = 0;
            end else begin
                case (mode0)
                    IDLE: if (p_ss) begin m_mode = RUN; m_phase = 0; end
                    RUN: begin
                        m_phase++;
                        if (m_phase == DIV) begin
                            m_phase = 0;
                            if (m_cnt == MAXC) m_mode = OVF;
                            else               m_cnt++;
                        end
                        if (p_ss && m_mode == RUN) m_mode = HOLD;
                    end
                    HOLD: if (p_ss) m_mode = RUN;
                    default: ;
                endcase
`ifdef CRONOMETRO_LAP_EN
                if (p_v && (mode0 == OVF || (mode0 == RUN && !p_ss))) begin
                    if (!m_lap_on) begin m_lap = cnt0; m_lap_on = 1; end
                    else           m_lap_on = 0;
                end
`endif
            end
            p_ss = ss & ~l_ss;
            p_z  = z & ~l_z;
            p_v  = v & ~l_v;
        end
        l_ss = ss; l_z = z; l_v = v;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: drive on the falling edge, predict the next edge.
    task automatic step(input bit r, input bit ss, input bit z, input bit v);
        @(negedge clk);
        rst = r; btn_start_stop = ss; btn_zerar = z; btn_volta = v;
        model_step(r, ss, z, v);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic press(input bit ss, input bit z, input bit v);
        step(0, ss, z, v);
        step(0, 0, 0, 0);
    endtask

    // Run until the model says the display shows target; bounded.
    task automatic run_to(input int target, input int budget);
        int n = 0;
        while ((m_lap_on ? m_lap : m_cnt) != target && n < budget) begin
            step(0, 0, 0, 0);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL run_to: count never reached %0d within %0d clocks", target, budget);
        end
        step(0, 0, 0, 0);   // let the registered output catch up
    endtask

    // Monitor: compare every presented output cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bin !== e.bin) begin
                    errors++;
                    $display("FAIL bin cyc=%0d got=%0d want=%0d", e.cyc, bin, e.bin);
                end
                checks++;
                if (contando !== e.c) begin
                    errors++;
                    $display("FAIL contando cyc=%0d got=%0b want=%0b", e.cyc, contando, e.c);
                end
                checks++;
                if (estouro !== e.e) begin
                    errors++;
                    $display("FAIL estouro cyc=%0d got=%0b want=%0b", e.cyc, estouro, e.e);
                end
                checks++;
                if (volta_ativa !== e.v) begin
                    errors++;
                    $display("FAIL volta_ativa cyc=%0d got=%0b want=%0b", e.cyc, volta_ativa, e.v);
                end
            end
        end
    end

    initial begin
        bit rl, sl, zl, vl;
        // 1: reset, start, count to 3
        repeat (3) step(1, 0, 0, 0);
        press(1, 0, 0);
        idle(35);
        // 2: pause at 5 for 50 clocks, resume keeps the phase
        run_to(5, 40);
        press(1, 0, 0);
        idle(50);
        press(1, 0, 0);
        run_to(6, 20);
        // 3: saturate at MAX, start_stop ignored in overflow, then clear
        run_to(MAXC, 200);
        idle(25);
        press(1, 0, 0);
        idle(15);
        press(0, 0, 1);     // lap in overflow (no effect without the lap feature)
        idle(5);
        press(0, 1, 0);
        idle(5);
        // 4: start_stop and zerar together while counting
        press(1, 0, 0);
        idle(15);
        press(1, 1, 0);
        idle(5);
        // 5: reset mid-count with start held through and after reset
        press(1, 0, 0);
        run_to(7, 100);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        idle(3);
        // 6: lap freeze at 4, release after 30 clocks; volta ignored in pause
        press(1, 0, 0);
        run_to(4, 60);
        press(0, 0, 1);
        idle(30);
        press(0, 0, 1);
        idle(5);
        press(1, 0, 0);
        press(0, 0, 1);
        idle(12);
        press(1, 0, 0);
        press(0, 0, 1);
        idle(10);
        press(0, 1, 0);
        idle(3);
        // random levels
        rl = 0; sl = 0; zl = 0; vl = 0;
        for (int i = 0; i < 4000; i++) begin
            rl = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 29) == 0)  sl = ~sl;
            if ($urandom_range(0, 199) == 0) zl = ~zl;
            if ($urandom_range(0, 39) == 0)  vl = ~vl;
            step(rl, sl, zl, vl);
        end
        idle(3);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
